user_locked_regfile: RTL and testbench

USER_LOCKED_REGFILE -- requirements
Module: user_locked_regfile

---
 rtl/user_lock_pkg.sv | 21 ++
 rtl/user_lock_entry.sv | 80 ++++++++
 rtl/user_locked_regfile.sv | 108 ++++++++++
 tb/tb_user_locked_regfile.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/user_lock_pkg.sv
// Shared definitions for the user-locked register file.
//   req_op_e         : request opcode encoding on req_op
//   lock_state_e     : per-register lock FSM states
//   ADMIN_ID_DEFAULT : default privileged user ID
package user_lock_pkg;

  typedef enum logic [1:0] {
    OP_WRITE     = 2'd0,
    OP_SET_OWNER = 2'd1,
    OP_LOCK      = 2'd2,
    OP_RSVD      = 2'd3
  } req_op_e;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  localparam logic [1:0] ADMIN_ID_DEFAULT = 2'h2;

endpackage

// File: rtl/user_lock_entry.sv
// One register of the user-locked register file: data, owner, lock FSM and
// the permission check for the requested operation.
//   clk, rst_n : clock, synchronous active-low reset
//   req_en     : a request is addressed to this entry this cycle
//   req_op     : requested operation (req_op_e encoding)
//   usr_id     : requester ID
//   wdata      : write data / new owner in [UID_W-1:0]
//   allow      : requested op is permitted on this entry (combinational)
//   data       : current register contents
//   locked     : entry is in the LOCKED state
module user_lock_entry
  import user_lock_pkg::*;
#(
  parameter int unsigned      DATA_W   = 8,
  parameter int unsigned      UID_W    = 2,
  parameter logic [UID_W-1:0] ADMIN_ID = UID_W'(ADMIN_ID_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_en,
  input  logic [1:0]        req_op,
  input  logic [UID_W-1:0]  usr_id,
  input  logic [DATA_W-1:0] wdata,
  output logic              allow,
  output logic [DATA_W-1:0] data,
  output logic              locked
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [UID_W-1:0]  owner_q, owner_d;
  lock_state_e       lock_q, lock_d;

  logic    is_admin;
  logic    is_owner;
  logic    unlocked;
  req_op_e op;

  always_comb begin
    op       = req_op_e'(req_op);
    is_admin = (usr_id == ADMIN_ID);
    is_owner = (usr_id == owner_q);
    unlocked = (lock_q == ST_UNLOCKED);

    case (op)
      OP_WRITE:     allow = unlocked && (is_owner || is_admin);
      OP_SET_OWNER: allow = unlocked && is_admin;
      // LOCK on an already locked entry is a successful no-op
      OP_LOCK:      allow = !unlocked || is_owner || is_admin;
      default:      allow = 1'b0;
    endcase

    data_d  = data_q;
    owner_d = owner_q;
    lock_d  = lock_q;
    if (req_en && allow) begin
      case (op)
        OP_WRITE:     data_d  = wdata;
        OP_SET_OWNER: owner_d = wdata[UID_W-1:0];
        OP_LOCK:      lock_d  = ST_LOCKED;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      owner_q <= ADMIN_ID;
      lock_q  <= ST_UNLOCKED;
    end else begin
      data_q  <= data_d;
      owner_q <= owner_d;
      lock_q  <= lock_d;
    end
  end

  assign data   = data_q;
  assign locked = (lock_q == ST_LOCKED);

endmodule

// File: rtl/user_locked_regfile.sv
// Register file with per-register owner and sticky lock.
//   clk, rst_n   : clock, synchronous active-low reset
//   usr_id       : requester ID, sampled with req_valid
//   req_valid    : request strobe
//   req_op       : 0 WRITE, 1 SET_OWNER, 2 LOCK, 3 reserved
//   req_addr     : target register index
//   req_data     : write data; SET_OWNER uses [UID_W-1:0]
//   rsp_valid    : one-cycle response pulse, cycle after the request
//   rsp_err      : request rejected (valid with rsp_valid)
//   rd_addr      : read index
//   rd_data      : combinational read, 0 for out-of-range index
//   lock_status  : bit i set when register i is locked
//   err_count    : saturating count of rejected requests
module user_locked_regfile
  import user_lock_pkg::*;
#(
  parameter int unsigned      DATA_W   = 8,
  parameter int unsigned      DEPTH    = 4,
  parameter int unsigned      UID_W    = 2,
  parameter logic [UID_W-1:0] ADMIN_ID = UID_W'(ADMIN_ID_DEFAULT),
  parameter int unsigned      ERR_W    = 4,
  localparam int unsigned     AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [UID_W-1:0]  usr_id,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic              rsp_err,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DEPTH-1:0]  lock_status,
  output logic [ERR_W-1:0]  err_count
);

  logic [DEPTH-1:0]  sel;
  logic [DEPTH-1:0]  allow;
  logic [DATA_W-1:0] data_arr [DEPTH];

  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  // Only indices below DEPTH can match, so out-of-range addresses select
  // nothing and are rejected through the empty allow mask.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      sel[i] = (req_addr == AW'(i));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    user_lock_entry #(
      .DATA_W   (DATA_W),
      .UID_W    (UID_W),
      .ADMIN_ID (ADMIN_ID)
    ) u_entry (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_en (req_valid && sel[g]),
      .req_op (req_op),
      .usr_id (usr_id),
      .wdata  (req_data),
      .allow  (allow[g]),
      .data   (data_arr[g]),
      .locked (lock_status[g])
    );
  end

  always_comb begin
    rsp_valid_d = req_valid;
    rsp_err_d   = req_valid && ((sel & allow) == '0);
    err_count_d = err_count_q;
    if (rsp_err_d && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rd_addr == AW'(i)) begin
        rd_data = data_arr[i];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_user_locked_regfile.sv
module tb_user_locked_regfile;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 3;
  localparam int UID_W  = 2;
  localparam int ADMIN  = 2;
  localparam int ERR_W  = 4;
  localparam int AW     = 2;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [UID_W-1:0]  usr_id;
  logic              req_valid;
  logic [1:0]        req_op;
  logic [AW-1:0]     req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_err;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DEPTH-1:0]  lock_status;
  logic [ERR_W-1:0]  err_count;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents, owners, lock flags, error count
  int m_data   [DEPTH];
  int m_owner  [DEPTH];
  bit m_locked [DEPTH];
  int m_err;

  user_locked_regfile #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .UID_W    (UID_W),
    .ADMIN_ID (2'h2),
    .ERR_W    (ERR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .usr_id      (usr_id),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .lock_status (lock_status),
    .err_count   (err_count)
  );

  always #10 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_data[i]   = 0;
      m_owner[i]  = ADMIN;
      m_locked[i] = 1'b0;
    end
    m_err = 0;
  endfunction

  // Returns 1 when the request is rejected
  function automatic bit model_req(int uid, int op, int addr, int data);
    bit rej;
    bit perm;
    rej = 1'b1;
    if (op != 3 && addr < DEPTH) begin
      perm = (uid == m_owner[addr]) || (uid == ADMIN);
      if (op == 0) begin
        if (!m_locked[addr] && perm) begin
          m_data[addr] = data & 8'hFF;
          rej = 1'b0;
        end
      end else if (op == 1) begin
        if (!m_locked[addr] && uid == ADMIN) begin
          m_owner[addr] = data & 3;
          rej = 1'b0;
        end
      end else begin
        if (m_locked[addr]) rej = 1'b0;
        else if (perm) begin
          m_locked[addr] = 1'b1;
          rej = 1'b0;
        end
      end
    end
    if (rej && m_err < ERR_MAX) m_err++;
    return rej;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int lv;
    int exp;
    lv = 0;
    for (int i = 0; i < DEPTH; i++) if (m_locked[i]) lv |= (1 << i);
    check("lock_status", 32'(lock_status), 32'(lv));
    check("err_count", 32'(err_count), 32'(m_err));
    for (int i = 0; i < 4; i++) begin
      rd_addr = AW'(i);
      #1;
      exp = (i < DEPTH) ? m_data[i] : 0;
      check($sformatf("rd_data[%0d]", i), 32'(rd_data), 32'(exp));
    end
  endtask

  // Drive one cycle of request inputs at negedge, check the response after
  // the following rising edge, end on the next negedge.
  task automatic cycle(input logic v, input int uid, input int op, input int addr,
                       input int data, output logic exp_err);
    usr_id    = UID_W'(uid);
    req_valid = v;
    req_op    = 2'(op);
    req_addr  = AW'(addr);
    req_data  = DATA_W'(data);
    exp_err   = 1'b0;
    if (v) exp_err = model_req(uid, op, addr, data);
    @(posedge clk);
    #1;
    check("rsp_valid", 32'(rsp_valid), 32'(v));
    if (v) check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check_state();
    @(negedge clk);
  endtask

  initial begin
    logic e;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    usr_id    = '0;
    req_op    = '0;
    req_addr  = '0;
    req_data  = '0;
    rd_addr   = '0;
    model_reset();

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    check_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Admin write reg0
    cycle(1'b1, 2, 0, 0, 8'hA5, e);
    rd_addr = 2'd0; #1;
    check("reg0_a5", 32'(rd_data), 32'hA5);
    @(negedge clk);

    // Ownership and non-owner write
    cycle(1'b1, 2, 1, 1, 1, e);
    cycle(1'b1, 1, 0, 1, 8'h3C, e);
    cycle(1'b1, 0, 0, 1, 8'hFF, e);
    check("err_after_bad_write", 32'(err_count), 32'd1);

    // Lock reg1; admin cannot write or re-own it; LOCK again is a no-op
    cycle(1'b1, 1, 2, 1, 0, e);
    check("lock_0010", 32'(lock_status), 32'b010);
    cycle(1'b1, 2, 0, 1, 8'h00, e);
    cycle(1'b1, 2, 1, 1, 3, e);
    cycle(1'b1, 0, 2, 1, 0, e);
    rd_addr = 2'd1; #1;
    check("reg1_held", 32'(rd_data), 32'h3C);
    @(negedge clk);

    // Out of range address and reserved op, then saturation
    cycle(1'b1, 2, 0, 3, 8'h11, e);
    cycle(1'b1, 2, 3, 0, 8'h22, e);
    for (int i = 0; i < 20; i++) cycle(1'b1, 2, 3, i % 4, i, e);
    check("err_saturated", 32'(err_count), 32'd15);

    // Reset coincident with a write
    rst_n     = 1'b0;
    req_valid = 1'b1;
    usr_id    = 2'd2;
    req_op    = 2'd0;
    req_addr  = 2'd0;
    req_data  = 8'h77;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_no_rsp", 32'(rsp_valid), 32'(0));
    check_state();
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 1'b0;
    cycle(1'b0, 0, 0, 0, 0, e);

    // Ten back-to-back writes to alternating registers
    for (int i = 0; i < 10; i++) cycle(1'b1, 2, 0, i % 2, 8'h10 + i, e);

    // Randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      cycle(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 255)), e);
    end

    req_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
